// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flex
// Purpose  : Single-clock parametrised FIFO with standard or first-word-fall-
//            through read mode. It has programmable almost-full/almost-empty
//            thresholds, a fill-level output and sticky overflow/underflow
//            flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    parameter int FWFT  = 0,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic [AW:0]      af_level,
    input  logic [AW:0]      ae_level,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [AW:0]   c_FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;

    // Status decodes come straight from the count register, so a threshold
    // change is reflected without waiting for a clock edge.
    assign w_full       = (r_count == c_FULL_COUNT);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= af_level);
    assign almost_empty = (r_count <= ae_level);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A read is never accepted when empty. A write at full is allowed only
    // when a read frees the slot on the same edge.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // Storage array: written on every accepted write. It is intentionally not reset.
    always_ff @(posedge clk1) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and fill level. The pointers wrap naturally at AW bits.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Sticky error flags. A new error event wins over a coincident clear.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~clr_err) | (wr_en & ~w_wr_acc);
            r_underflow <= (r_underflow & ~clr_err) | (rd_en & ~w_rd_acc);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is presented combinationally. The output is forced to
            // zero while empty, so it never exposes stale or unreset storage.
            always_comb begin
                dout       = '0;
                dout_valid = ~w_empty;
                if (!w_empty) begin
                    dout = r_mem[r_rd_ptr];
                end
            end
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_dout_valid;

            // Registered read: data lands one clock after the accepted read.
            // The data is held afterwards, and valid is a one-cycle pulse.
            always_ff @(posedge clk1 or posedge reset) begin
                if (reset) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_flex
// Purpose  : Self-checking bench for sync_fifo_flex. It drives a standard-mode
//            instance and an FWFT instance with the same stimulus, and compares
//            both against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flex;

    localparam int c_W = 8;
    localparam int c_D = 16;
    localparam int c_A = 4;

    logic             clk1 = 1'b0;
    logic             reset;
    logic             wr_en, rd_en, clr_err;
    logic [c_W-1:0]   din;
    logic [c_A:0]     af_level, ae_level;

    logic [c_W-1:0]   s_dout,  f_dout;
    logic             s_dv,    f_dv;
    logic [c_A:0]     s_count, f_count;
    logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    // Reference model state
    logic [c_W-1:0]   m_q[$];
    logic [c_W-1:0]   m_dout;
    logic             m_dv;
    logic             m_ovf, m_unf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk1 = ~clk1;

    sync_fifo_flex #(.WIDTH(c_W), .DEPTH(c_D), .FWFT(0)) u_std (
        .clk1(clk1), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .dout_valid(s_dv), .af_level(af_level), .ae_level(ae_level),
        .count(s_count), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_flex #(.WIDTH(c_W), .DEPTH(c_D), .FWFT(1)) u_fwft (
        .clk1(clk1), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .dout_valid(f_dv), .af_level(af_level), .ae_level(ae_level),
        .count(f_count), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("s_count", 64'(s_count), 64'(n));
        check("s_full",  64'(s_full),  64'(n == c_D));
        check("s_empty", 64'(s_empty), 64'(n == 0));
        check("s_af",    64'(s_af),    64'(n >= int'(af_level)));
        check("s_ae",    64'(s_ae),    64'(n <= int'(ae_level)));
        check("s_ovf",   64'(s_ovf),   64'(m_ovf));
        check("s_unf",   64'(s_unf),   64'(m_unf));
        check("s_dout",  64'(s_dout),  64'(m_dout));
        check("s_dv",    64'(s_dv),    64'(m_dv));
        check("f_count", 64'(f_count), 64'(n));
        check("f_full",  64'(f_full),  64'(n == c_D));
        check("f_empty", 64'(f_empty), 64'(n == 0));
        check("f_af",    64'(f_af),    64'(n >= int'(af_level)));
        check("f_ae",    64'(f_ae),    64'(n <= int'(ae_level)));
        check("f_ovf",   64'(f_ovf),   64'(m_ovf));
        check("f_unf",   64'(f_unf),   64'(m_unf));
        check("f_dv",    64'(f_dv),    64'(n != 0));
        if (n != 0) begin
            check("f_dout", 64'(f_dout), 64'(m_q[0]));
        end
    endtask

    // One clock cycle: drive the inputs, update the model at the edge, and check after the edge.
    task automatic step(input logic we, input logic re, input logic [c_W-1:0] d, input logic ce);
        logic rd_acc, wr_acc;
        wr_en = we; rd_en = re; din = d; clr_err = ce;
        @(posedge clk1);
        rd_acc = re && (m_q.size() > 0);
        wr_acc = we && ((m_q.size() < c_D) || rd_acc);
        m_ovf  = (m_ovf && !ce) || (we && !wr_acc);
        m_unf  = (m_unf && !ce) || (re && !rd_acc);
        m_dv   = rd_acc;
        if (rd_acc) m_dout = m_q.pop_front();
        if (wr_acc) m_q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    // Assert reset between edges and check that its effect is immediate, then release it.
    task automatic do_reset();
        reset = 1'b1;
        m_q.delete();
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        check_all();
        check("f_dout_rst", 64'(f_dout), 64'(0));
        @(posedge clk1);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        af_level = 5'd12; ae_level = 5'd3;
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        #2;
        do_reset();

        // Reset mid-stream, then check that the first word written afterwards is read first.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        do_reset();
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'h78, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill and drain with pointer wrap. The thresholds are crossed along the way.
        for (int i = 0; i < 16; i++) begin
            if (i == 11) begin
                af_level = 5'd10;
                #1;
                check_all();
                check("af_live", 64'(s_af), 64'(1));
            end
            step(1'b1, 1'b0, 8'(i), 1'b0);
        end
        af_level = 5'd12;
        step(1'b1, 1'b1, 8'h99, 1'b0);          // at full: both accepted
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 16; i < 24; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);          // at empty: write only, underflow
        step(1'b0, 1'b0, 8'h00, 1'b1);          // clear

        // Overflow: 17 writes, then clear, then clear while a write is rejected.
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Single word through an empty FIFO in both read modes.
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional threshold changes, clears and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                af_level = 5'($urandom_range(1, c_D));
                ae_level = 5'($urandom_range(0, c_D - 1));
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                int bias;
                bias = (c / 300) % 3;
                step(1'b1 && ($urandom_range(0, 9) < ((bias == 0) ? 7 : (bias == 1) ? 3 : 5)),
                     1'b1 && ($urandom_range(0, 9) < ((bias == 0) ? 3 : (bias == 1) ? 7 : 5)),
                     8'($urandom), ($urandom_range(0, 19) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, for same-domain buffering between datapath stages.
- Adds generic width and depth, a first-word-fall-through (FWFT) mode, runtime-programmable almost-full and almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags with a clear input.
- Storage is a register array, sized DEPTH x WIDTH.

Parameters:
WIDTH, 64, data word width in bits (>=1)
DEPTH, 512, number of entries; power of two, >=4
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
AW, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk1  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
din  input  WIDTH  write data
rd_en  input  1  read request (FWFT: acknowledge/pop of the head word)
dout  output  WIDTH  read data
dout_valid  output  1  dout holds a valid word (meaning depends on FWFT)
af_level  input  AW+1  almost-full threshold, 1..DEPTH
ae_level  input  AW+1  almost-empty threshold, 0..DEPTH-1
count  output  AW+1  current fill level, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_level
almost_empty  output  1  count <= ae_level
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0, dout = 0, dout_valid = 0, overflow = underflow = 0.
  - Flags follow count: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first accepted write after release lands at entry 0.
- Accept rules, evaluated on the same edge:
  - wr_acc = wr_en & (!full | rd_acc)
  - rd_acc = rd_en & !empty
  - Write when full is accepted only if a read is accepted in the same cycle.
  - A read when empty is never accepted, even with a simultaneous write. The written word becomes available next cycle.
- Pointers:
  - wr_ptr increments on wr_acc; rd_ptr increments on rd_acc.
  - Both wrap DEPTH-1 -> 0 (modulo AW bits).
- count updates each cycle:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- full, empty, almost_full and almost_empty are combinational decodes of the count register and threshold ports. They change in the cycle after the causing edge, with no extra latency.
- Thresholds may change at any time. Flags reflect new values immediately.
- Errors:
  - overflow sets on wr_en & !wr_acc; underflow sets on rd_en & !rd_acc.
  - Both stay set until clr_err or reset.
  - If clr_err coincides with a new error event, the flag stays set (set wins).
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid = 1 for exactly the next cycle. Read latency is 1 clock.
  - Without rd_acc, dout holds its last value and dout_valid = 0.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally and dout_valid = !empty.
  - rd_acc pops the head; the next word (if any) appears in the following cycle.
  - A word written into an empty FIFO is visible on dout one cycle after the write edge.
- Ordering is strict FIFO. No data is lost or duplicated across wrap-around.

Test Plan:
- Reset/idle (WIDTH=8, DEPTH=16): assert reset mid-stream -> count=0, empty=1, almost_empty=1, full=0, dout=0, errors=0 with no clock edge. First write after release is read back first.
- Fill/drain with wrap: write 0..15 -> full=1, count=16. Read 8, write 16..23, read all 16 -> data 8..23 in order, empty=1, wr_ptr and rd_ptr both wrapped.
- Simultaneous access: at full, wr_en=rd_en=1 -> both accepted, count stays 16, overflow=0. At empty, wr_en=rd_en=1 -> write accepted, read rejected, count=1, underflow=1.
- Thresholds: af_level=12, ae_level=3. Fill one per cycle -> almost_empty drops at count=4, almost_full rises at count=12. Change af_level to 10 at count=11 -> almost_full=1 same cycle.
- Error sticky/clear: write 17 words into DEPTH=16 -> overflow=1 and word 16 is not stored. clr_err=1 one cycle -> overflow=0. clr_err with a simultaneous rejected write -> overflow stays 1.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle dout=0xA5, dout_valid=1. Pulse rd_en -> dout_valid=0, empty=1. Standard mode with the same stimulus -> dout=0xA5 one cycle after rd_en, dout_valid for 1 cycle.
